// File: rtl/wb_pkg.sv
// Shared types and helpers for the wait-state Wishbone RAM.
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaiting,
        StResp
    } state_e;

    // Number of byte-offset bits in a byte address for a data_w-bit bus.
    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Word-organised storage: synchronous read, byte-enabled write, no reset on contents.
module wb_ram_array #(
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_ram_wait.sv
// Wishbone classic slave RAM with WAIT programmable wait states per access.
// Define WB_RAM_ERR_EN to terminate out-of-range word indices with err_o instead of wrapping.
module wb_ram_wait
    import wb_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   adr_i,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic [DATA_W/8-1:0] sel_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o
);

    localparam int OFF_W = byte_off_w(DATA_W);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  latch;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdat_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W-1:0]     rdata;
    logic [DEPTH_LOG2-1:0] idx_in;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  ram_we;
    logic                  term;
    logic                  rd_ack;
    logic                  oor_q;
    logic                  unused_adr;

    // Upper index bits beyond the array wrap away; offset bits are don't-care.
    assign idx_in     = adr_i[OFF_W +: DEPTH_LOG2];
    assign unused_adr = ^adr_i;

`ifdef WB_RAM_ERR_EN
    logic oor_in;
    assign oor_in = |adr_i[ADDR_W-1:OFF_W+DEPTH_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (latch) begin
            oor_q <= oor_in;
        end
    end
`else
    assign oor_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            StIdle: begin
                if (cyc_i && stb_i) begin
                    latch = 1'b1;
                    if (WAIT == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWaiting;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            StWaiting: begin
                if (!cyc_i) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StResp;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q   <= we_i;
                idx_q  <= idx_in;
                wdat_q <= dat_i;
                sel_q  <= sel_i;
            end
        end
    end

    // In IDLE the array reads the live address so WAIT=0 has data ready in RESP.
    assign ram_addr = (state_q == StIdle) ? idx_in : idx_q;
    assign term     = (state_q == StResp) && cyc_i;
    assign ack_o    = term && !oor_q;
    `ifdef WB_RAM_ERR_EN
    assign err_o    = term && oor_q;
    `else
    assign err_o    = 1'b0;
    `endif
    assign ram_we   = ack_o && we_q;
    assign rd_ack   = ack_o && !we_q;
    assign dat_o    = rd_ack ? rdata : dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
        end else if (rd_ack) begin
            dat_q <= rdata;
        end
    end

    wb_ram_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (sel_q),
        .addr (ram_addr),
        .wdata(wdat_q),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_wb_ram_wait.sv
// Scoreboard bench for wb_ram_wait: a WAIT=2 instance and a WAIT=0 instance for streaming.
module tb_wb_ram_wait;

    localparam int TB_WAIT = 2;
    localparam logic [127:0] DEAD = 128'h0123456789abcdef00112233deadbeef;

    typedef struct packed {
        logic         is_err;
        logic         chk;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we, ack, err;
    logic [15:0]  adr, sel;
    logic [127:0] dat_w, dat_r;
    logic         cyc0, stb0, we0, ack0, err0;
    logic [15:0]  adr0, sel0;
    logic [127:0] dat_w0, dat_r0;

    exp_t q[$];
    exp_t q0[$];
    exp_t me, me0;
    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    int   last_ack0 = -1;
    int   ack_cnt0 = 0;
    logic stream0 = 1'b0;
    logic [127:0] last_rd;
    logic [127:0] d0 [4];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    wb_ram_wait #(.DATA_W(128), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT(TB_WAIT)) u_dut (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .dat_i(dat_w), .sel_i(sel), .dat_o(dat_r), .ack_o(ack), .err_o(err)
    );

    wb_ram_wait #(.DATA_W(128), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0), .adr_i(adr0),
        .dat_i(dat_w0), .sel_i(sel0), .dat_o(dat_r0), .ack_o(ack0), .err_o(err0)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the WAIT=2 instance.
    always @(negedge clk) begin
        if (!rst && (ack || err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: got ack=%0b err=%0b expected none", ack, err);
            end else begin
                me = q.pop_front();
                check("term_onehot", 128'(ack ^ err), 128'd1);
                check("term_is_err", 128'(err), 128'(me.is_err));
                if (me.chk) check("dat_o", dat_r, me.data);
            end
        end
    end

    // Monitor for the WAIT=0 instance.
    always @(negedge clk) begin
        if (!rst && (ack0 || err0)) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term0: got ack=%0b err=%0b expected none", ack0, err0);
            end else begin
                me0 = q0.pop_front();
                check("term0_is_err", 128'(err0), 128'(me0.is_err));
                if (me0.chk) check("dat_o0", dat_r0, me0.data);
            end
            if (stream0 && ack0) begin
                if (last_ack0 >= 0) check("stream_gap", 128'(cycle_cnt - last_ack0), 128'd2);
                last_ack0 = cycle_cnt;
                ack_cnt0++;
            end
        end
    end

    // One transaction on the WAIT=2 instance; inputs are scrambled after the latch edge.
    task automatic xfer(input logic w, input logic [15:0] a, input logic [127:0] d,
                        input logic [15:0] s, input logic e_err, input logic [127:0] e_dat);
        exp_t e;
        int   n;
        e.is_err = e_err;
        e.chk    = e_err || !w;
        e.data   = e_dat;
        q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        we = ~w; adr = ~a; dat_w = ~d; sel = ~s;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack || err) break;
        end
        check("latency", 128'(n), 128'(TB_WAIT + 1));
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic write0(input logic [15:0] a, input logic [127:0] d);
        exp_t e;
        e = '0;
        q0.push_back(e);
        cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = a; dat_w0 = d; sel0 = '1;
        @(posedge clk); #1;
        we0 = 1'b0; adr0 = ~a; stb0 = 1'b0;
        @(posedge clk); #1;
        cyc0 = 1'b0;
    endtask

    initial begin
        int n_term;
        exp_t e;
        rst = 1'b1;
        cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 0;
        cyc0 = 0; stb0 = 0; we0 = 0; adr0 = 0; dat_w0 = 0; sel0 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 128'(ack), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_dat", dat_r, 128'd0);
        check("rst_dat0", dat_r0, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full write then readback, and dat_o hold after the ack cycle.
        xfer(1'b1, 16'h0010, DEAD, 16'hffff, 1'b0, '0);
        xfer(1'b0, 16'h0010, '0, '0, 1'b0, DEAD);
        @(negedge clk);
        check("dat_hold", dat_r, DEAD);

        // Byte-select write onto a zeroed word.
        xfer(1'b1, 16'h0020, '0, 16'hffff, 1'b0, '0);
        xfer(1'b1, 16'h0020, {16{8'hff}}, 16'h0001, 1'b0, '0);
        xfer(1'b0, 16'h0020, '0, '0, 1'b0, 128'hff);

        // sel=0 write changes nothing; byte offset bits are ignored.
        xfer(1'b1, 16'h0010, ~DEAD, 16'h0000, 1'b0, '0);
        xfer(1'b0, 16'h001f, '0, '0, 1'b0, DEAD);

        // cyc dropped in the cycle after acceptance aborts the write.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0010; dat_w = ~DEAD; sel = 16'hffff;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        n_term = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack || err) n_term++;
        end
        check("abort_no_term", 128'(n_term), 128'd0);
        @(posedge clk); #1;
        xfer(1'b0, 16'h0010, '0, '0, 1'b0, DEAD);

        // Word 1024: error termination or alias onto word 0.
        xfer(1'b1, 16'h0000, 128'h11112222333344445555666677778888, 16'hffff, 1'b0, '0);
        xfer(1'b0, 16'h0000, '0, '0, 1'b0, 128'h11112222333344445555666677778888);
        last_rd = 128'h11112222333344445555666677778888;
`ifdef WB_RAM_ERR_EN
        xfer(1'b1, 16'h4000, 128'hcafe, 16'hffff, 1'b1, last_rd);
        xfer(1'b0, 16'h0000, '0, '0, 1'b0, last_rd);
`else
        xfer(1'b1, 16'h4000, 128'hcafe, 16'hffff, 1'b0, '0);
        xfer(1'b0, 16'h0000, '0, '0, 1'b0, 128'hcafe);
`endif

        // WAIT=0 instance: preload, then stream four reads with stb held high.
        for (int i = 0; i < 4; i++) begin
            d0[i] = {4{32'(i + 1) * 32'h01010101}};
            write0(16'(i * 16), d0[i]);
        end
        stream0 = 1'b1;
        cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adr0 = 16'(i * 16);
            e.is_err = 1'b0; e.chk = 1'b1; e.data = d0[i];
            q0.push_back(e);
            @(posedge clk); #1;
            adr0 = 16'hfff0;
            if (i == 3) stb0 = 1'b0;
            @(posedge clk); #1;
        end
        cyc0 = 1'b0;
        @(negedge clk);
        stream0 = 1'b0;
        check("stream_acks", 128'(ack_cnt0), 128'd4);

        // Reset while WAITING: outputs clear at once, write is dropped.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0010; dat_w = 128'h5a5a; sel = 16'hffff;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ack", 128'(ack), 128'd0);
        check("midrst_err", 128'(err), 128'd0);
        check("midrst_dat", dat_r, 128'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_term = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack || err) n_term++;
        end
        check("postrst_no_term", 128'(n_term), 128'd0);
        @(posedge clk); #1;
        xfer(1'b0, 16'h0010, '0, '0, 1'b0, DEAD);

        @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'd0);
        check("queue0_drained", 128'(q0.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ram_wait.md
WB_RAM_WAIT -- requirements
Module: wb_ram_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 128: data bus width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: log2 of word count.
REQ-004 SHALL have parameter WAIT, default 2, range 0..15: wait states inserted before each response.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports cyc_i input 1, stb_i input 1, we_i input 1: Wishbone classic cycle, strobe and write enable.
REQ-008 SHALL have port adr_i, input, ADDR_W: byte address.
REQ-009 SHALL have ports dat_i input DATA_W and sel_i input DATA_W/8: write data and byte selects.
REQ-010 SHALL have port dat_o, output, DATA_W: read data.
REQ-011 SHALL have ports ack_o output 1 and err_o output 1: normal and error termination.

Function
REQ-012 SHALL take word index = adr_i[ADDR_W-1:log2(DATA_W/8)] and ignore the low byte-offset bits.
REQ-013 SHALL implement FSM IDLE -> WAITING -> RESP -> IDLE; with WAIT=0, IDLE goes directly to RESP.
REQ-014 In IDLE with cyc_i&stb_i high at edge k, SHALL latch adr_i, we_i, dat_i, sel_i and load the wait counter with WAIT.
REQ-015 SHALL decrement the counter once per cycle in WAITING and enter RESP on the edge where it reaches 0.
REQ-016 SHALL assert exactly one of ack_o/err_o for exactly one cycle, namely cycle k+1+WAIT.
REQ-017 Reads SHALL drive dat_o with the latched word during the ack cycle; dat_o SHALL hold its last value otherwise.
REQ-018 Writes SHALL update only the bytes whose sel_i bit was set, at the end of the ack cycle; a read in the following transaction SHALL return the new data.
REQ-019 sel_i=0 on a write SHALL be acked with no storage change.
REQ-020 If cyc_i falls in WAITING or RESP, SHALL return to IDLE next edge with no ack/err and no write.
REQ-021 After RESP, SHALL spend one cycle in IDLE; stb_i still high then starts a new transaction, giving back-to-back throughput of one per WAIT+2 cycles.
REQ-022 SHALL ignore changes on adr_i/dat_i/sel_i/we_i after the latch edge until the next IDLE acceptance.

Reset
REQ-023 rst SHALL force state IDLE, counter 0, ack_o=0, err_o=0, dat_o=0 immediately; storage SHALL NOT be cleared.
REQ-024 rst asserted mid-transaction SHALL abort it with no write and no termination.

Configuration
REQ-025 With WB_RAM_ERR_EN defined, a word index >= 2**DEPTH_LOG2 SHALL be terminated with err_o (same latency), with no write and dat_o unchanged.
REQ-026 Without WB_RAM_ERR_EN, err_o SHALL be tied 0 and the index SHALL wrap modulo 2**DEPTH_LOG2, always acked.

Structure
REQ-027 Package wb_pkg SHALL hold the FSM state enum and the byte-offset-width constant function.
REQ-028 Storage SHALL be a sub-module wb_ram_array (synchronous read, byte-enabled write, DATA_W x 2**DEPTH_LOG2).

Verification
REQ-029 WAIT=2: write 0x...DEADBEEF to addr 0x0010 with sel=all-ones; the ack is in cycle k+3; a readback of 0x0010 returns 0x...DEADBEEF in its ack cycle.
REQ-030 Write sel=16'h0001 with data 0xFF to a word holding 0 -> readback shows only byte 0 = 0xFF.
REQ-031 WAIT=0: stb held high for 4 reads -> an ack every 2 cycles, 4 acks total.
REQ-032 cyc_i dropped in cycle k+1 of a write -> no ack, and a readback shows the old data.
REQ-033 With WB_RAM_ERR_EN and DEPTH_LOG2=10, access to word 1024 -> err_o pulse with no ack; without the macro, the same access aliases word 0.
REQ-034 rst pulsed in WAITING -> ack_o/err_o/dat_o read 0 in the same cycle; the FSM is IDLE after release.
